// File: rtl/cache_fill_ctrl.sv
// 2-way, 2-line, 8-byte-line cache controller: hit/miss lookup, victim choice, byte-serial line fill.
// Hits answer in the request cycle; a miss fills through mem_req/mem_ack with no timeout, then settles one cycle.
module cache_fill_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              rdline,
    output logic [2:0]        rdoffset,
    output logic              rdentry,
    output logic              wrline,
    output logic [2:0]        wroffset,
    output logic              wrentry,
    output logic              wren,
    output logic [7:0]        wrdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int TAG_W = ADDR_W - 4;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SETTLE} state_t;

    state_t                     state_q, state_d;
    logic [1:0][1:0]            valid_q, valid_d;   // [way][line]
    logic [1:0][1:0][TAG_W-1:0] tag_q, tag_d;
    logic [1:0]                 lru_q, lru_d;
    logic [TAG_W-1:0]           fill_tag_q, fill_tag_d;
    logic                       fill_line_q, fill_line_d;
    logic                       victim_q, victim_d;
    logic [2:0]                 fill_cnt_q, fill_cnt_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       post_fill_q, post_fill_d;
    logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]           miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0] req_tag;
    logic             req_line;
    logic             hit0, hit1, hit;
    logic             victim_sel;
    logic             last_ack;

    assign req_tag  = cpu_addr[ADDR_W-1:4];
    assign req_line = cpu_addr[3];
    assign hit0     = cpu_req & valid_q[0][req_line] & (tag_q[0][req_line] == req_tag);
    assign hit1     = cpu_req & valid_q[1][req_line] & (tag_q[1][req_line] == req_tag);
    assign hit      = hit0 | hit1;
    assign last_ack = (state_q == S_FILL) & mem_ack & (fill_cnt_q == 3'd7);

    // Empty ways are always used before evicting anything.
    assign victim_sel = !valid_q[0][req_line] ? 1'b0 :
                        !valid_q[1][req_line] ? 1'b1 : lru_q[req_line];

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cpu_req && !flush && !hit) state_d = S_FILL;
            S_FILL:   if (last_ack) state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        wren      = 1'b0;
        case (state_q)
            S_IDLE: cpu_ready = hit & ~flush;
            S_FILL: begin
                mem_req = 1'b1;
                wren    = mem_ack;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        lru_d        = lru_q;
        fill_tag_d   = fill_tag_q;
        fill_line_d  = fill_line_q;
        victim_d     = victim_q;
        fill_cnt_d   = fill_cnt_q;
        flush_pend_d = flush_pend_q;
        post_fill_d  = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (hit) begin
                    lru_d[req_line] = hit0;
                    // The first hit after a fill was already counted as that fill's miss.
                    if (!post_fill_q && !(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
                end else if (cpu_req) begin
                    fill_tag_d                    = req_tag;
                    fill_line_d                   = req_line;
                    victim_d                      = victim_sel;
                    valid_d[victim_sel][req_line] = 1'b0;
                    fill_cnt_d                    = '0;
                    if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end
            S_FILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_ack) begin
                    fill_cnt_d = fill_cnt_q + 3'd1;
                    if (fill_cnt_q == 3'd7) begin
                        tag_d[victim_q][fill_line_q]   = fill_tag_q;
                        valid_d[victim_q][fill_line_q] = 1'b1;
                        lru_d[fill_line_q]             = ~victim_q;
                    end
                end
            end
            S_SETTLE: begin
                post_fill_d  = 1'b1;
                flush_pend_d = 1'b0;
                if (flush || flush_pend_q) valid_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            tag_q        <= '0;
            lru_q        <= '0;
            fill_tag_q   <= '0;
            fill_line_q  <= 1'b0;
            victim_q     <= 1'b0;
            fill_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            post_fill_q  <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            lru_q        <= lru_d;
            fill_tag_q   <= fill_tag_d;
            fill_line_q  <= fill_line_d;
            victim_q     <= victim_d;
            fill_cnt_q   <= fill_cnt_d;
            flush_pend_q <= flush_pend_d;
            post_fill_q  <= post_fill_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign rdline     = cpu_addr[3];
    assign rdoffset   = cpu_addr[2:0];
    assign rdentry    = hit1;
    assign wrline     = fill_line_q;
    assign wroffset   = fill_cnt_q;
    assign wrentry    = victim_q;
    assign wrdata     = mem_rdata;
    assign mem_addr   = {fill_tag_q, fill_line_q, fill_cnt_q};
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: lookup/fill vector table plus hand sequences for ack gaps, flush and reset mid-fill.
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [7:0]  cpu_addr;
    logic        cpu_ready;
    logic        flush;
    logic        rdline;
    logic [2:0]  rdoffset;
    logic        rdentry;
    logic        wrline;
    logic [2:0]  wroffset;
    logic        wrentry;
    logic        wren;
    logic [7:0]  wrdata;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       way;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        logic       is_flush;
        logic [7:0] addr;
        logic       hit;
        logic       way;
        int         gap;
        int         hits;
        int         misses;
    } vec_t;
    localparam int NV = 14;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    cache_fill_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
        .flush(flush), .rdline(rdline), .rdoffset(rdoffset), .rdentry(rdentry),
        .wrline(wrline), .wroffset(wroffset), .wrentry(wrentry), .wren(wren), .wrdata(wrdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic logic [7:0] mem_byte(input logic [7:0] a);
        return (a ^ 8'hA5) + 8'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every RAM write must match the next byte the stimulus handed to the memory port.
    always @(negedge clk) begin
        wr_t e;
        #2;
        if (wren === 1'b1) begin
            chk("wren_with_pending_ack", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("wr_mem_addr", mem_addr, e.addr);
                chk("wroffset", wroffset, e.addr[2:0]);
                chk("wrline", wrline, e.addr[3]);
                chk("wrentry", wrentry, e.way);
                chk("wrdata", wrdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic ack_byte(input logic [7:0] a, input logic way, input logic do_flush, input logic do_reset);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = mem_byte(a);
        flush     = do_flush;
        reset     = do_reset;
        sb_q.push_back('{addr: a, data: mem_byte(a), way: way});
        #1;
        chk("ack_mem_req", mem_req, 1);
    endtask

    task automatic do_fill(input logic [7:0] a, input logic way, input int gap, input int flush_at);
        logic [7:0] ba;
        for (int i = 0; i < 8; i++) begin
            ba = {a[7:3], 3'(i)};
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                mem_ack = 1'b0;
                flush   = 1'b0;
                #1;
                chk("gap_mem_addr", mem_addr, ba);
                chk("gap_wren", wren, 0);
                chk("gap_mem_req", mem_req, 1);
            end
            ack_byte(ba, way, (i == flush_at), 1'b0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        flush   = 1'b0;
        #1;
        chk("settle_ready", cpu_ready, 0);
        chk("settle_mem_req", mem_req, 0);
    endtask

    task automatic access(input logic [7:0] a, input logic exp_hit, input logic way, input int gap,
                          input int hits, input int misses);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1;
        chk("lookup_ready", cpu_ready, exp_hit);
        chk("rdline", rdline, a[3]);
        chk("rdoffset", rdoffset, a[2:0]);
        if (exp_hit) begin
            chk("hit_rdentry", rdentry, way);
        end else begin
            do_fill(a, way, gap, -1);
            @(negedge clk);
            #1;
            chk("post_fill_ready", cpu_ready, 1);
            chk("post_fill_rdentry", rdentry, way);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("hit_count", hit_count, hits);
        chk("miss_count", miss_count, misses);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_mem_req", mem_req, 0);
    endtask

    initial begin
        logic [7:0] ba;
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 8'h00; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'h00;

        //           flush addr   hit   way   gap hits misses
        vecs[0]  = '{1'b0, 8'h25, 1'b0, 1'b0, 0, 0, 1};
        vecs[1]  = '{1'b0, 8'h23, 1'b1, 1'b0, 0, 1, 1};
        vecs[2]  = '{1'b1, 8'h23, 1'b0, 1'b0, 0, 1, 1};
        vecs[3]  = '{1'b0, 8'h45, 1'b0, 1'b0, 0, 1, 2};
        vecs[4]  = '{1'b0, 8'h65, 1'b0, 1'b1, 0, 1, 3};
        vecs[5]  = '{1'b0, 8'h45, 1'b1, 1'b0, 0, 2, 3};
        vecs[6]  = '{1'b0, 8'h85, 1'b0, 1'b1, 0, 2, 4};
        vecs[7]  = '{1'b0, 8'h45, 1'b1, 1'b0, 0, 3, 4};
        vecs[8]  = '{1'b0, 8'h65, 1'b0, 1'b1, 0, 3, 5};
        vecs[9]  = '{1'b0, 8'h82, 1'b0, 1'b0, 0, 3, 6};
        vecs[10] = '{1'b0, 8'h6A, 1'b0, 1'b0, 0, 3, 7};
        vecs[11] = '{1'b0, 8'h6E, 1'b1, 1'b0, 0, 4, 7};
        vecs[12] = '{1'b0, 8'h61, 1'b1, 1'b1, 0, 5, 7};
        vecs[13] = '{1'b0, 8'h99, 1'b0, 1'b1, 5, 5, 8};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wren", wren, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_flush) begin
                @(negedge clk);
                cpu_req  = 1'b1;
                cpu_addr = vecs[i].addr;
                flush    = 1'b1;
                #1;
                chk("flush_idle_ready", cpu_ready, 0);
                @(negedge clk);
                cpu_req = 1'b0;
                flush   = 1'b0;
                #1;
                chk("flush_hit_count", hit_count, vecs[i].hits);
                chk("flush_miss_count", miss_count, vecs[i].misses);
            end else begin
                access(vecs[i].addr, vecs[i].hit, vecs[i].way, vecs[i].gap, vecs[i].hits, vecs[i].misses);
            end
        end

        // Flush during a fill: the line completes, then is dropped, so the held request refills.
        do_reset();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 8'h10;
        #1;
        chk("fp_lookup_ready", cpu_ready, 0);
        do_fill(8'h10, 1'b0, 0, 3);
        @(negedge clk);
        #1;
        chk("fp_remiss_ready", cpu_ready, 0);
        chk("fp_miss_count_mid", miss_count, 1);
        do_fill(8'h10, 1'b0, 0, -1);
        @(negedge clk);
        #1;
        chk("fp_ready", cpu_ready, 1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("fp_hit_count", hit_count, 0);
        chk("fp_miss_count", miss_count, 2);

        // Reset on the 4th ack aborts the fill.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 8'h37;
        #1;
        chk("ra_lookup_ready", cpu_ready, 0);
        for (int i = 0; i < 3; i++) begin
            ba = 8'h30 | 8'(i);
            ack_byte(ba, 1'b1, 1'b0, 1'b0);
        end
        cpu_req = 1'b0;
        ack_byte(8'h33, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("ra_mem_req", mem_req, 0);
        chk("ra_wren", wren, 0);
        chk("ra_hit_count", hit_count, 0);
        chk("ra_miss_count", miss_count, 0);
        access(8'h37, 1'b0, 1'b0, 0, 0, 1);

        // Request dropped mid-fill: the line still becomes valid.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 8'h5B;
        #1;
        chk("rd_lookup_ready", cpu_ready, 0);
        ack_byte(8'h58, 1'b0, 1'b0, 1'b0);
        ack_byte(8'h59, 1'b0, 1'b0, 1'b0);
        cpu_req = 1'b0;
        for (int i = 2; i < 8; i++) begin
            ba = 8'h58 | 8'(i);
            ack_byte(ba, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rd_settle_mem_req", mem_req, 0);
        @(negedge clk);
        access(8'h5B, 1'b1, 1'b0, 0, 1, 2);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
